// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding fetch controller owning PC and IR with redirect, stall and halt; define IFU_PERF_CNT_EN for saturating fetch/stall counters
module ifu_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INSTR_BYTES = 4,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic ifu_ctrl_clock_in,
  input  logic ifu_ctrl_reset_in,
  input  logic halt_signal_in,
  input  logic stall_in,
  input  logic redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic mem_req_valid_out,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_out,
  input  logic mem_req_ready_in,
  input  logic mem_rsp_valid_in,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_in,
  output logic ir_valid_out,
  output logic [DATA_WIDTH-1:0] ir_data_out,
  output logic [ADDR_WIDTH-1:0] ir_pc_out,
  output logic ifu_ctrl_pc_set_out,
  output logic ifu_ctrl_ir_set_out,
  output logic [2:0] ifu_ctrl_state_out
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_fetch_count_out,
  output logic [PERF_CNT_WIDTH-1:0] perf_stall_count_out
`endif
);
  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, HOLD = 3'd3, HALT = 3'd4} state_t;
  state_t state_q, state_d, run_state;
  logic [ADDR_WIDTH-1:0] pc_q, fetch_pc_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic discard_q, discard_d, accept, load, from_buf, park, ir_free;
  assign ir_free = !ir_valid_out || !stall_in;
  assign run_state = halt_signal_in ? HALT : REQ;
  assign mem_req_valid_out = state_q == REQ;
  assign mem_req_addr_out = pc_q;
  assign ifu_ctrl_pc_set_out = accept || redirect_valid_in;
  assign ifu_ctrl_ir_set_out = load;
  assign ifu_ctrl_state_out = state_q;
  always_comb begin
    state_d = state_q;
    discard_d = discard_q;
    accept = 1'b0;
    load = 1'b0;
    from_buf = 1'b0;
    park = 1'b0;
    case (state_q)
      IDLE: state_d = run_state;
      REQ: begin
        accept = mem_req_ready_in;
        state_d = mem_req_ready_in ? WAIT : halt_signal_in ? HALT : REQ;
      end
      WAIT: if (mem_rsp_valid_in) begin
        load = !discard_q && ir_free;
        park = !discard_q && !ir_free;
        discard_d = 1'b0;
        state_d = discard_q ? REQ : ir_free ? run_state : HOLD;
      end
      HOLD: begin
        load = ir_free;
        from_buf = 1'b1;
        state_d = ir_free ? run_state : HOLD;
      end
      HALT: state_d = halt_signal_in ? HALT : REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_valid_in) begin
      load = 1'b0;
      park = 1'b0;
      if (state_q == REQ && mem_req_ready_in) discard_d = 1'b1;
      if (state_q == WAIT) begin
        discard_d = !mem_rsp_valid_in;
        state_d = mem_rsp_valid_in ? REQ : WAIT;
      end
      if (state_q == HOLD) state_d = REQ;
    end
  end
  always_ff @(posedge ifu_ctrl_clock_in or negedge ifu_ctrl_reset_in)
    if (!ifu_ctrl_reset_in) begin
      state_q <= IDLE;
      pc_q <= RESET_VECTOR;
      fetch_pc_q <= '0;
      buf_q <= '0;
      discard_q <= 1'b0;
      ir_valid_out <= 1'b0;
      ir_data_out <= '0;
      ir_pc_out <= '0;
    end else begin
      state_q <= state_d;
      discard_q <= discard_d;
      pc_q <= redirect_valid_in ? redirect_pc_in : accept ? pc_q + ADDR_WIDTH'(INSTR_BYTES) : pc_q;
      if (accept) fetch_pc_q <= pc_q;
      if (park) buf_q <= mem_rsp_data_in;
      ir_valid_out <= load || (ir_valid_out && stall_in && !redirect_valid_in);
      if (load) begin
        ir_data_out <= from_buf ? buf_q : mem_rsp_data_in;
        ir_pc_out <= fetch_pc_q;
      end
    end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge ifu_ctrl_clock_in or negedge ifu_ctrl_reset_in)
    if (!ifu_ctrl_reset_in) begin
      perf_fetch_count_out <= '0;
      perf_stall_count_out <= '0;
    end else begin
      if (load && !(&perf_fetch_count_out)) perf_fetch_count_out <= perf_fetch_count_out + 1'b1;
      if (ir_valid_out && stall_in && !(&perf_stall_count_out)) perf_stall_count_out <= perf_stall_count_out + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: randomized scoreboard bench for ifu_fetch_ctrl against an in-order fetch-stream model
module tb_ifu_fetch_ctrl;
  localparam logic [31:0] RV = 32'h100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic halt, stall, rd_v, rdy, rsp_v;
  logic [31:0] rd_pc, rsp_d;
  logic req_v, ir_v, pc_set, ir_set;
  logic [31:0] req_a, ir_d, ir_pc;
  logic [2:0] st;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_f, perf_s;
`endif
  int n_chk = 0, n_pass = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_e;
  logic [31:0] exp_pc = RV;
  logic [31:0] pend_addr, t;
  bit pend_on = 0, expect_drop = 0, saw_zero = 0, last_set = 0, s_acc = 0;
  int pend_cnt = 0, lat_min = 1, lat_max = 1, stale = 0, edge_no = 0, acc_cnt = 0, hl = 0, a0 = 0;
  int acc_edges[$];

  ifu_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .ifu_ctrl_clock_in(clk),
    .ifu_ctrl_reset_in(rst_n),
    .halt_signal_in(halt),
    .stall_in(stall),
    .redirect_valid_in(rd_v),
    .redirect_pc_in(rd_pc),
    .mem_req_valid_out(req_v),
    .mem_req_addr_out(req_a),
    .mem_req_ready_in(rdy),
    .mem_rsp_valid_in(rsp_v),
    .mem_rsp_data_in(rsp_d),
    .ir_valid_out(ir_v),
    .ir_data_out(ir_d),
    .ir_pc_out(ir_pc),
    .ifu_ctrl_pc_set_out(pc_set),
    .ifu_ctrl_ir_set_out(ir_set),
    .ifu_ctrl_state_out(st)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_count_out(perf_f),
    .perf_stall_count_out(perf_s)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rst_chk();
    chk("rst_req_valid", req_v, 0);
    chk("rst_ir_valid", ir_v, 0);
    chk("rst_pc_set", pc_set, 0);
    chk("rst_ir_set", ir_set, 0);
    chk("rst_state", st, 0);
    chk("rst_req_addr", req_a, RV);
    chk("rst_ir_data", ir_d, 0);
    chk("rst_ir_pc", ir_pc, 0);
  endtask

  task automatic cyc(input bit r, input bit s, input bit h, input bit d, input logic [31:0] tg);
    bit rsp_now, bogus;
    logic [31:0] a;
    rdy = r; stall = s; halt = h; rd_v = d; rd_pc = tg;
    rsp_v = 1'b0; rsp_d = '0; rsp_now = 0; bogus = 0;
    if (stale > 0) begin
      rsp_v = 1'b1; rsp_d = 32'hDEAD_BEEF; stale--; bogus = 1;
    end else if (pend_on) begin
      if (pend_cnt == 0) begin
        rsp_v = 1'b1; rsp_d = mem_word(pend_addr); pend_on = 0; rsp_now = 1;
      end else pend_cnt--;
    end
    @(negedge clk);
    s_acc = req_v && rdy;
    a = req_a;
    chk("pc_set", pc_set, s_acc || d);
    if (bogus) chk("late_rsp_ir_set", ir_set, 0);
    if (expect_drop && rsp_now) begin
      chk("drop_ir_set", ir_set, 0);
      expect_drop = 0;
    end
    @(posedge clk);
    edge_no++;
    if (d) sb.delete();
    if (s_acc) begin
      chk("req_addr", a, exp_pc);
      exp_pc = exp_pc + 32'd4;
      acc_cnt++;
      if (acc_edges.size() < 3) acc_edges.push_back(edge_no);
      if (a == 32'h0) saw_zero = 1;
      if (!d) sb.push_back({a, mem_word(a)});
      pend_on = 1;
      pend_addr = a;
      pend_cnt = $urandom_range(lat_min, lat_max) - 1;
    end
    if (d) exp_pc = tg;
    #1;
    rd_v = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (last_set) chk("ir_valid_after_set", ir_v, 1);
      if (ir_v && !stall) begin
        if (sb.size() == 0) chk("sb_occupancy", sb.size(), 1);
        else begin
          mon_e = sb.pop_front();
          chk("ir_pc", ir_pc, mon_e[63:32]);
          chk("ir_data", ir_d, mon_e[31:0]);
        end
      end
    end
    last_set = rst_n && ir_set;
  end

  initial begin
    halt = 0; stall = 0; rd_v = 0; rd_pc = '0; rdy = 0; rsp_v = 0; rsp_d = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_chk();
    rst_n = 1'b1;
    edge_no = 0;
    repeat (40) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) chk("first_req_edge", i < acc_edges.size() ? acc_edges[i] : -1, 2 + 2 * i);
    chk("zero_wait_rate", acc_cnt, 20);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) a0 = acc_cnt;
      cyc(1, 1, 0, 0, 0);
    end
    chk("stall_no_req", acc_cnt - a0, 0);
    chk("stall_ir_held", ir_v, 1);
    repeat (10) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) a0 = acc_cnt;
      cyc(1, 0, 1, 0, 0);
    end
    chk("halt_no_req", acc_cnt - a0, 0);
    chk("halt_state", st, 4);
    repeat (10) cyc(1, 0, 0, 0, 0);
    lat_min = 3; lat_max = 3;
    s_acc = 0;
    for (int i = 0; i < 10 && !s_acc; i++) cyc(1, 0, 0, 0, 0);
    chk("wait_entered", s_acc, 1);
    expect_drop = 1;
    cyc(0, 0, 0, 1, 32'h200);
    chk("redirect_ir_inval", ir_v, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);
    chk("drop_observed", expect_drop, 0);
    lat_min = 1; lat_max = 1;
    repeat (10) cyc(1, 0, 0, 0, 0);
    saw_zero = 0;
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC);
    repeat (12) cyc(1, 0, 0, 0, 0);
    chk("pc_wrap", saw_zero, 1);
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (hl > 0) hl--;
      else if ($urandom_range(0, 99) < 2) hl = $urandom_range(3, 15);
      t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, hl > 0, $urandom_range(0, 99) < 4, t);
    end
    lat_min = 3; lat_max = 3;
    s_acc = 0;
    for (int i = 0; i < 40 && !s_acc; i++) cyc(1, 0, 0, 0, 0);
    chk("wait_before_reset", s_acc, 1);
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk();
    pend_on = 0;
    sb.delete();
    exp_pc = RV;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_no = 0;
    stale = 2;
    lat_min = 1; lat_max = 1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (20) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 60 && (sb.size() > 0 || pend_on); i++) cyc(0, 0, 0, 0, 0);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Parametrised next-generation instruction fetch controller: owns the PC, issues single-outstanding fetch requests over a valid/ready memory port, and captures responses into an instruction register (IR) with valid/stall backpressure.
- Adds redirect (branch/jump), decode stall and orderly halt on top of the existing fetch/halt control.
- Sits between the PC/redirect sources in the core and the decode stage.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
DATA_WIDTH, 32, instruction word width
RESET_VECTOR, 0, PC value after reset (ADDR_WIDTH bits)
INSTR_BYTES, 4, PC increment per fetch
PERF_CNT_WIDTH, 32, width of optional performance counters

Ports:
ifu_ctrl_clock_in  in  1  clock; all state updates on rising edge
ifu_ctrl_reset_in  in  1  asynchronous reset, active-low
halt_signal_in  in  1  level halt request
stall_in  in  1  decode not ready; IR must hold
redirect_valid_in  in  1  one-cycle PC redirect strobe
redirect_pc_in  in  ADDR_WIDTH  redirect target
mem_req_valid_out  out  1  fetch request valid
mem_req_addr_out  out  ADDR_WIDTH  fetch address
mem_req_ready_in  in  1  memory accepts request
mem_rsp_valid_in  in  1  response data valid
mem_rsp_data_in  in  DATA_WIDTH  fetched instruction
ir_valid_out  out  1  IR holds a valid instruction
ir_data_out  out  DATA_WIDTH  IR instruction
ir_pc_out  out  ADDR_WIDTH  PC of IR instruction
ifu_ctrl_pc_set_out  out  1  PC register updated this cycle
ifu_ctrl_ir_set_out  out  1  IR loaded this cycle
ifu_ctrl_state_out  out  3  current FSM state encoding

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_VECTOR, all valid/set outputs 0, ir_data_out=0, ir_pc_out=0, discard flag 0, counters 0.
- States: IDLE=0, REQ=1, WAIT=2, HOLD=3, HALT=4.
- IDLE: one cycle, then HALT if halt_signal_in=1, else REQ. First request asserted on the 2nd rising edge after reset release.
- REQ: mem_req_valid_out=1, addr=pc.
  - Accept (ready=1): pc<=pc+INSTR_BYTES (wraps modulo 2^ADDR_WIDTH), record fetch PC, ->WAIT.
  - halt=1 while ready=0: request withdrawn, ->HALT.
- WAIT: at most one request outstanding; mem_req_valid_out=0.
  - On rsp_valid with discard=1: drop data, clear discard, ->REQ.
  - Otherwise, if the IR is free, or consumed this cycle (ir_valid & !stall_in): load IR, set ir_valid, ->REQ (->HALT if halt=1).
  - Otherwise ->HOLD with data buffered internally.
- HOLD: load IR from buffer when the IR is consumed, then ->REQ/HALT as above.
- HALT: no requests; IR retains its contents and may still be consumed; ->REQ when halt=0.
- IR consumption: ir_valid clears when ir_valid & !stall_in, unless reloaded in the same cycle.
- Redirect (any state), highest priority:
  - pc<=redirect_pc_in.
  - IR and HOLD buffer invalidated.
  - In WAIT: set discard.
  - In REQ when the same-cycle accept occurs: set discard, go to WAIT.
  - HOLD: ->REQ.
  - HALT: PC updated, state unchanged.
  - Redirect overrides pc increment.
- Halt never abandons an accepted request; the response is collected first.
- ifu_ctrl_pc_set_out=1 on any pc write (accept or redirect). ifu_ctrl_ir_set_out=1 on any IR load.
- Zero-wait memory (ready=1, response 1 cycle after accept): one instruction per 2 cycles.
- Responses arriving outside WAIT are ignored (protocol error, not flagged).

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds outputs perf_fetch_count_out [PERF_CNT_WIDTH] and perf_stall_count_out [PERF_CNT_WIDTH].
  - perf_fetch_count_out increments on each IR load.
  - perf_stall_count_out increments each cycle ir_valid & stall_in.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset release, RESET_VECTOR=0x100, zero-wait memory -> requests at 0x100, 0x104, 0x108 on cycles 2, 4, 6; IR valid cycles 4, 6, 8; pc_set pulses on each accept.
- stall_in held 5 cycles with IR full -> one response buffered in HOLD, no new request, IR unchanged; stall release -> buffered word loads next cycle, fetch resumes at next PC.
- redirect_valid_in to 0x200 while in WAIT -> that response dropped (no ir_set), next request addr 0x200, IR invalidated.
- halt asserted while in WAIT -> outstanding response loaded into IR, then HALT with no requests; halt released -> REQ at correct sequential PC.
- pc=0xFFFFFFFC accepted -> next request addr 0x00000000.
- Async reset asserted mid-WAIT -> all outputs 0 immediately, pc=RESET_VECTOR; late response after release ignored.
